// File: rtl/reg_bank_ws.sv
// -----------------------------------------------------------------------------
// reg_bank_ws
//
// Slave-side register bank with wait states, placed behind an AHB slave
// interface. Accesses are byte-addressed and byte-strobed. Each access takes
// WAIT_STATES stall cycles followed by a one-cycle registered response that
// carries ready/error/rd_data. Individual registers can be made read-only
// through RO_MASK.
//
// Optional feature macro: REG_FILE_LOCK_EN
//   When this macro is defined, register REG_FILE_DEPTH-1 becomes a lock
//   register. Only its bit0 is stored; all other bits read as 0. While the
//   lock bit is 1, any write to registers 0..REG_FILE_DEPTH-2 returns an
//   error. Writes to the lock register itself are always allowed, and the
//   lane 0 strobe must be set for such a write to change the lock bit.
//   When the macro is undefined, the last register is an ordinary register.
//
// Ports
//   clk      in   1               rising-edge clock
//   rst      in   1               asynchronous active-low reset
//   rd_en    in   1               read request
//   wr_en    in   1               write request
//   address  in   ADDR_WIDTH      byte address (word index = address[ADDR_WIDTH-1:2])
//   wr_data  in   DATA_WIDTH      write data
//   wr_strb  in   DATA_WIDTH/8    byte-lane write enables
//   rd_data  out  DATA_WIDTH      read data; nonzero only in the response cycle
//   ready    out  1               0 while stalled, 1 when idle or responding
//   error    out  1               error flag; valid only in the response cycle
// -----------------------------------------------------------------------------
module reg_bank_ws #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 16,
    parameter int WAIT_STATES    = 1,
    parameter logic [REG_FILE_DEPTH-1:0] RO_MASK = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    ready,
    output logic                    error
);

    localparam int IDX_W  = $clog2(REG_FILE_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WADR_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Latched request
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [WADR_W-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;

    // Register file and registered response
    logic [DATA_WIDTH-1:0] regs_q [REG_FILE_DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [REG_FILE_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic             accept;
    logic             enter_resp;
    logic [IDX_W-1:0] t_idx;
    logic             t_oob;
    logic             t_ro;
    logic             t_lock_err;
    logic             t_err;

`ifdef REG_FILE_LOCK_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_FILE_DEPTH - 1);
    logic is_lock_reg;
    logic lock;
`endif

    // Byte offset bits carry no information for word-aligned access.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, address[1:0]};

    // A request is taken whenever the bank is not stalling.
    assign accept = (state_q != S_WAIT) && (rd_en || wr_en);

    // The edge that enters RESP is the one that commits writes and captures
    // read data. It is either a zero-wait accept or the last WAIT cycle.
    assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Response fields are forced to zero outside RESP.
    // ------------------------------------------------------------------
    always_comb begin
        ready   = 1'b1;
        error   = 1'b0;
        rd_data = '0;
        case (state_q)
            S_WAIT: ready = 1'b0;
            S_RESP: begin
                error   = err_q;
                rd_data = rdata_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture. The _d values double as "the transaction being
    // completed": on a zero-wait accept they are the live inputs, and when
    // leaving WAIT they are the latched copy.
    // ------------------------------------------------------------------
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        if (accept) begin
            rd_d    = rd_en;
            wr_d    = wr_en;
            addr_d  = address[ADDR_WIDTH-1:2];
            wdata_d = wr_data;
            strb_d  = wr_strb;
        end
    end

    assign t_idx = addr_d[IDX_W-1:0];
    assign t_oob = |addr_d[WADR_W-1:IDX_W];

`ifdef REG_FILE_LOCK_EN
    assign lock        = regs_q[LAST_IDX][0];
    assign is_lock_reg = (t_idx == LAST_IDX);
    // The lock register itself is never read-only and never locked.
    assign t_ro        = RO_MASK[t_idx] && !is_lock_reg;
    assign t_lock_err  = wr_d && lock && !is_lock_reg;
`else
    assign t_ro        = RO_MASK[t_idx];
    assign t_lock_err  = 1'b0;
`endif

    assign t_err = t_oob || (rd_d && wr_d) || (wr_d && t_ro) || t_lock_err;

    // ------------------------------------------------------------------
    // Commit and read capture on the edge entering RESP
    // ------------------------------------------------------------------
    always_comb begin
        regs_d  = regs_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = t_err;
            rdata_d = '0;
            if (!t_err && wr_d) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (strb_d[b]) begin
                        regs_d[t_idx][8*b +: 8] = wdata_d[8*b +: 8];
                    end
                end
`ifdef REG_FILE_LOCK_EN
                // Only bit0 of the lock register is storage.
                if (is_lock_reg) begin
                    regs_d[LAST_IDX] = {{(DATA_WIDTH-1){1'b0}},
                                        (strb_d[0] ? wdata_d[0] : lock)};
                end
`endif
            end
            if (!t_err && rd_d) begin
                rdata_d = regs_q[t_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < REG_FILE_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    // Request payload needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        strb_q  <= strb_d;
    end

endmodule

// File: tb/tb_reg_bank_ws.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_ws
//
// Two instances of reg_bank_ws: dut0 (WAIT_STATES=1, RO_MASK=16'h0001) and
// dut1 (WAIT_STATES=0, RO_MASK=0). A transaction-level model computes, for
// each issued request, the cycle of its response and the expected
// ready/error/rd_data; a per-cycle compare process checks both DUTs against
// these expectations. Literal checks pin key values by hand.
// -----------------------------------------------------------------------------
module tb_reg_bank_ws;

    localparam int MAXC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  strb_s  [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        error_s [2];

    reg_bank_ws #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_DEPTH(16),
        .WAIT_STATES(1), .RO_MASK(16'h0001)
    ) dut0 (
        .clk(clk), .rst(rst_s[0]), .rd_en(rd_s[0]), .wr_en(wr_s[0]),
        .address(addr_s[0]), .wr_data(wdata_s[0]), .wr_strb(strb_s[0]),
        .rd_data(rdata_s[0]), .ready(ready_s[0]), .error(error_s[0])
    );

    reg_bank_ws #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_DEPTH(16),
        .WAIT_STATES(0), .RO_MASK(16'h0000)
    ) dut1 (
        .clk(clk), .rst(rst_s[1]), .rd_en(rd_s[1]), .wr_en(wr_s[1]),
        .address(addr_s[1]), .wr_data(wdata_s[1]), .wr_strb(strb_s[1]),
        .rd_data(rdata_s[1]), .ready(ready_s[1]), .error(error_s[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done   = 0;

    // Per-cycle expectations and the register contents the model believes in
    bit          exp_rdy [2][MAXC];
    bit          exp_err [2][MAXC];
    logic [31:0] exp_dat [2][MAXC];
    logic [31:0] m_regs  [2][16];

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic bit ro_bit(input int d, input int idx);
        logic [15:0] m;
        m = (d == 0) ? 16'h0001 : 16'h0000;
        return m[idx[3:0]];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction model: request accepted on edge 'acc'; response visible in
    // cycle acc+WS, stalled (ready=0) for the WS cycles before that.
    task automatic model(input int d, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s, input int acc,
                         output int r);
        int idx;
        bit err;
        bit lockreg;
        logic [31:0] mask;
        logic [31:0] rdat;
        idx     = int'(a >> 2);
        err     = (idx >= 16) || (rd && wr);
        lockreg = 0;
`ifdef REG_FILE_LOCK_EN
        lockreg = (idx == 15);
        if (!err && wr && !lockreg && m_regs[d][15][0]) err = 1;
`endif
        if (!err && wr && !lockreg && ro_bit(d, idx)) err = 1;
        rdat = 32'h0;
        if (!err && rd) rdat = m_regs[d][idx];
        if (!err && wr) begin
            if (lockreg) begin
                if (s[0]) m_regs[d][15] = {31'b0, dat[0]};
            end else begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                m_regs[d][idx] = (m_regs[d][idx] & ~mask) | (dat & mask);
            end
        end
        r = acc + ws(d);
        for (int c = acc; c < r && c < MAXC; c++) exp_rdy[d][c] = 0;
        if (r < MAXC) begin
            exp_rdy[d][r] = 1;
            exp_err[d][r] = err;
            exp_dat[d][r] = rdat;
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 16; i++) m_regs[d][i] = 32'h0;
        for (int c = cyc + 1; c < MAXC; c++) begin
            exp_rdy[d][c] = 1;
            exp_err[d][c] = 0;
            exp_dat[d][c] = 32'h0;
        end
    endtask

    // Drive one request for a single cycle (inputs stay up until changed).
    task automatic issue(input int d, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s, output int r);
        @(negedge clk); #1;
        rd_s[d]    = rd;
        wr_s[d]    = wr;
        addr_s[d]  = a;
        wdata_s[d] = dat;
        strb_s[d]  = s;
        model(d, rd, wr, a, dat, s, cyc + 1, r);
    endtask

    task automatic idle(input int d);
        @(negedge clk); #1;
        rd_s[d] = 0;
        wr_s[d] = 0;
    endtask

    task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] s, output int r);
        issue(d, rd, wr, a, dat, s, r);
        idle(d);
        for (int k = 1; k < ws(d); k++) @(negedge clk);
    endtask

    // Wait (bounded) for the sampling point of cycle tgt.
    task automatic at_cycle(input int tgt);
        int g;
        g = 0;
        while (cyc < tgt && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (cyc != tgt) chk("at_cycle_reached", cyc, tgt);
    endtask

    // Per-cycle compare of both DUTs against the model
    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done && cyc < MAXC) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("dut%0d_ready", d), {31'b0, ready_s[d]}, {31'b0, exp_rdy[d][cyc]});
                    chk($sformatf("dut%0d_error", d), {31'b0, error_s[d]}, {31'b0, exp_err[d][cyc]});
                    chk($sformatf("dut%0d_rd_data", d), rdata_s[d], exp_dat[d][cyc]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < MAXC; c++) begin
                exp_rdy[d][c] = 1;
                exp_err[d][c] = 0;
                exp_dat[d][c] = 32'h0;
            end
            for (int i = 0; i < 16; i++) m_regs[d][i] = 32'h0;
            rst_s[d] = 1; rd_s[d] = 0; wr_s[d] = 0;
            addr_s[d] = 0; wdata_s[d] = 0; strb_s[d] = 0;
        end
        #1;
        rst_s[0] = 0;
        rst_s[1] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("reset_error", {31'b0, error_s[0]}, 32'd0);
        chk("reset_rd_data", rdata_s[0], 32'h0);
        #1;
        rst_s[0] = 1;
        rst_s[1] = 1;

        // All registers read zero; one stall cycle before each response
        issue(0, 1, 0, 32'h0000_0014, 32'h0, 4'h0, r);
        at_cycle(r - 1);
        chk("t1_wait_ready", {31'b0, ready_s[0]}, 32'd0);
        #1; rd_s[0] = 0;
        at_cycle(r);
        chk("t1_resp_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("t1_resp_data", rdata_s[0], 32'h0);
        for (int i = 0; i < 16; i++) txn(0, 1, 0, 32'(i * 4), 32'h0, 4'h0, r);

        // Full write then strobed partial write merges byte lanes
        txn(0, 0, 1, 32'h08, 32'hDEAD_BEEF, 4'hF, r);
        txn(0, 0, 1, 32'h08, 32'h1122_3344, 4'h5, r);
        issue(0, 1, 0, 32'h08, 32'h0, 4'h0, r);
        chk("t2_model_pin", m_regs[0][2], 32'hDE22_BE44);
        idle(0);
        at_cycle(r);
        chk("t2_rd_data", rdata_s[0], 32'hDE22_BE44);
        chk("t2_error", {31'b0, error_s[0]}, 32'd0);

        // Out-of-range and conflicting requests
        txn(0, 1, 0, 32'h40, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t3_oob_rd_error", {31'b0, error_s[0]}, 32'd1);
        chk("t3_oob_rd_data", rdata_s[0], 32'h0);
        txn(0, 0, 1, 32'h44, 32'h5555_5555, 4'hF, r);
        at_cycle(r);
        chk("t3_oob_wr_error", {31'b0, error_s[0]}, 32'd1);
        txn(0, 1, 1, 32'h08, 32'h0000_0000, 4'hF, r);
        at_cycle(r);
        chk("t3_rdwr_error", {31'b0, error_s[0]}, 32'd1);
        txn(0, 1, 0, 32'h08, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t3_unchanged", rdata_s[0], 32'hDE22_BE44);
        txn(0, 0, 1, 32'h0C, 32'hABCD_0123, 4'h0, r);
        at_cycle(r);
        chk("t3_strb0_noerr", {31'b0, error_s[0]}, 32'd0);

        // Read-only register 0
        txn(0, 0, 1, 32'h00, 32'hFFFF_FFFF, 4'hF, r);
        at_cycle(r);
        chk("t4_ro_error", {31'b0, error_s[0]}, 32'd1);
        txn(0, 1, 0, 32'h00, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t4_ro_readback", rdata_s[0], 32'h0);

        // Zero wait states, back-to-back
        issue(1, 0, 1, 32'h04, 32'hCAFE_F00D, 4'hF, r);
        issue(1, 0, 1, 32'h0C, 32'h0BAD_BEEF, 4'hF, r);
        issue(1, 1, 0, 32'h04, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t5_b2b_data", rdata_s[1], 32'hCAFE_F00D);
        chk("t5_b2b_ready", {31'b0, ready_s[1]}, 32'd1);
        #1; rd_s[1] = 0;
        txn(1, 1, 0, 32'h0C, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t5_reg3", rdata_s[1], 32'h0BAD_BEEF);
        txn(1, 1, 0, 32'h40, 32'h0, 4'h0, r);
        txn(1, 0, 1, 32'h3C, 32'hA5A5_A5A4, 4'h3, r);
        txn(1, 1, 0, 32'h3C, 32'h0, 4'h0, r);
`ifdef REG_FILE_LOCK_EN
        chk("t5_lastreg_model", m_regs[1][15], 32'h0);
`else
        chk("t5_lastreg_model", m_regs[1][15], 32'h0000_A5A4);
`endif

`ifdef REG_FILE_LOCK_EN
        // Lock register gates writes to the rest of the bank
        txn(0, 0, 1, 32'h3C, 32'h0000_0001, 4'h1, r);
        txn(0, 0, 1, 32'h04, 32'h1234_5678, 4'hF, r);
        at_cycle(r);
        chk("t6_locked_error", {31'b0, error_s[0]}, 32'd1);
        txn(0, 1, 0, 32'h3C, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t6_lock_read", rdata_s[0], 32'h1);
        txn(0, 0, 1, 32'h3C, 32'h0000_0000, 4'hF, r);
        txn(0, 0, 1, 32'h04, 32'h1234_5678, 4'hF, r);
        at_cycle(r);
        chk("t6_unlocked_error", {31'b0, error_s[0]}, 32'd0);
        txn(0, 1, 0, 32'h04, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t6_unlocked_data", rdata_s[0], 32'h1234_5678);
`endif

        // Reset asserted during WAIT aborts the write
        issue(0, 0, 1, 32'h10, 32'h0000_0055, 4'hF, r);
        at_cycle(r - 1);
        #1;
        rst_s[0] = 0;
        rd_s[0]  = 0;
        wr_s[0]  = 0;
        model_reset(0);
        #1;
        chk("t7_async_ready", {31'b0, ready_s[0]}, 32'd1);
        @(negedge clk);
        chk("t7_reset_error", {31'b0, error_s[0]}, 32'd0);
        #1;
        rst_s[0] = 1;
        txn(0, 1, 0, 32'h10, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t7_discarded", rdata_s[0], 32'h0);
        txn(0, 1, 0, 32'h08, 32'h0, 4'h0, r);
        at_cycle(r);
        chk("t7_cleared", rdata_s[0], 32'h0);

        repeat (3) @(negedge clk);
        done = 1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
